clk_period_meter: RTL



---
 rtl/maze_timing_pkg.sv | 14 +
 rtl/sync_edge.sv | 33 +++
 rtl/clk_period_meter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/maze_timing_pkg.sv
// Shared timing definitions for the maze clocking/diagnostic blocks.
package maze_timing_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    TIMEOUT = 2'd3
  } meter_state_t;

  localparam int unsigned PERIOD_W       = 32;
  localparam int unsigned PERIOD_TIMEOUT = 250000000;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, plus a delay stage
// that yields single-cycle rise/fall pulses in the I_CLK domain.
module sync_edge (
  input  logic I_CLK,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // synchroniser chain; s3 is the previous synchronised value
  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= din;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign level = s2_r;
  assign rise  = s2_r & ~s3_r;
  assign fall  = ~s2_r & s3_r;

endmodule

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow external signal in I_CLK cycles,
// with a one-cycle valid strobe per period and a loss-of-signal timeout.
module clk_period_meter
  import maze_timing_pkg::*;
#(
  parameter int unsigned W           = PERIOD_W,
  parameter int unsigned TIMEOUT_CYC = PERIOD_TIMEOUT
) (
  input  logic         I_CLK,
  input  logic         rst,
  input  logic         sig_in,
  input  logic         en,
  output logic [W-1:0] period,
  output logic [W-1:0] high_time,
  output logic         period_valid,
  output logic         locked,
  output logic         timeout
);

  localparam logic [W-1:0] ZERO        = {W{1'b0}};
  localparam logic [W-1:0] ONE         = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] HMAX        = {W{1'b1}};
  localparam logic [W-1:0] TIMEOUT_LIM = W'(TIMEOUT_CYC);

  logic         level_s;
  logic         rise_s;
  logic         fall_s;
  logic [W-1:0] hcnt_nxt_s;
  logic [W-1:0] cnt_r;
  logic [W-1:0] hcnt_r;
  meter_state_t state_r;

  sync_edge u_sync_edge (
    .I_CLK (I_CLK),
    .rst   (rst),
    .din   (sig_in),
    .level (level_s),
    .rise  (rise_s),
    .fall  (fall_s)
  );

  // high-time counter restarts on rise and saturates while the signal stays high
  always_comb begin
    hcnt_nxt_s = hcnt_r;
    if (rise_s) begin
      hcnt_nxt_s = ONE;
    end else if (level_s && (hcnt_r != HMAX)) begin
      hcnt_nxt_s = hcnt_r + ONE;
    end else begin
      hcnt_nxt_s = hcnt_r;
    end
  end

  // measurement FSM with period/high-time capture and status flags
  always_ff @(posedge I_CLK or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= ZERO;
      hcnt_r       <= ZERO;
      period       <= ZERO;
      high_time    <= ZERO;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!en) begin
        // disable beats any coincident edge; results are kept
        state_r <= IDLE;
        cnt_r   <= ZERO;
        hcnt_r  <= ZERO;
        locked  <= 1'b0;
        timeout <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            state_r <= ARM;
            cnt_r   <= ZERO;
            hcnt_r  <= ZERO;
          end
          ARM: begin
            hcnt_r <= hcnt_nxt_s;
            if (rise_s) begin
              state_r <= MEASURE;
              cnt_r   <= ONE;
            end else if (cnt_r == TIMEOUT_LIM) begin
              state_r <= TIMEOUT;
              timeout <= 1'b1;
              locked  <= 1'b0;
            end else begin
              cnt_r <= cnt_r + ONE;
            end
          end
          MEASURE: begin
            hcnt_r <= hcnt_nxt_s;
            if (fall_s) begin
              high_time <= hcnt_r;
            end
            if (rise_s) begin
              period       <= cnt_r;
              period_valid <= 1'b1;
              locked       <= 1'b1;
              cnt_r        <= ONE;
            end else if (cnt_r == TIMEOUT_LIM) begin
              state_r <= TIMEOUT;
              timeout <= 1'b1;
              locked  <= 1'b0;
            end else begin
              cnt_r <= cnt_r + ONE;
            end
          end
          TIMEOUT: begin
            hcnt_r <= hcnt_nxt_s;
            if (rise_s) begin
              state_r <= MEASURE;
              cnt_r   <= ONE;
              timeout <= 1'b0;
            end else begin
              cnt_r <= cnt_r;
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= ZERO;
            hcnt_r  <= ZERO;
            locked  <= 1'b0;
            timeout <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
